// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32I execute stage: ALU op classes, ALU
// functions, funct3/funct7 codes and the multiply FSM state type.
package ex_stage_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_PASSB = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
    FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND, FN_PASSB
  } alu_fn_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // f7_alt is funct7[5]; op5 is opcode[5] (set for R-type, clear for OP-IMM)
  function automatic alu_fn_e alu_decode(input logic [1:0] alu_op,
                                         input logic [2:0] funct3,
                                         input logic       f7_alt,
                                         input logic       op5);
    alu_fn_e fn;
    fn = FN_ADD;
    case (alu_op)
      ALU_OP_ADD:   fn = FN_ADD;
      ALU_OP_SUB:   fn = FN_SUB;
      ALU_OP_PASSB: fn = FN_PASSB;
      default: begin
        case (funct3)
          3'b000:  fn = (op5 && f7_alt) ? FN_SUB : FN_ADD;
          3'b001:  fn = FN_SLL;
          3'b010:  fn = FN_SLT;
          3'b011:  fn = FN_SLTU;
          3'b100:  fn = FN_XOR;
          3'b101:  fn = f7_alt ? FN_SRA : FN_SRL;
          3'b110:  fn = FN_OR;
          default: fn = FN_AND;
        endcase
      end
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; all arithmetic wraps modulo 2^XLEN.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_fn_e         fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // Function select; shifts use only the low bits of operand B.
  always_comb begin
    result = '0;
    case (fn)
      FN_ADD:   result = a + b;
      FN_SUB:   result = a - b;
      FN_SLL:   result = a << shamt;
      FN_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      FN_XOR:   result = a ^ b;
      FN_SRL:   result = a >> shamt;
      FN_SRA:   result = $signed(a) >>> shamt;
      FN_OR:    result = a | b;
      FN_AND:   result = a & b;
      FN_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. Optional RV32M multiply enabled by macro RV32M_MUL_EN.
//
// Multiply FSM (RV32M_MUL_EN builds only):
//   state    | meaning
//   MUL_IDLE | normal ALU flow; a multiply here latches operands and stalls
//   MUL_BUSY | one shift-add step per cycle, down-counter from XLEN-1 to 0
//   MUL_DONE | sign-fix product, EX/MEM captures the selected word
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [31:0]           i_instruction,
  input  logic [XLEN-1:0]       i_read_data1,
  input  logic [XLEN-1:0]       i_read_data2,
  input  logic [XLEN-1:0]       i_imm,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_reg_write,
  input  logic                  i_alu_src,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic                  i_mem_to_reg,
  input  logic                  i_branch,
  input  logic [1:0]            i_alu_op,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_alu_result,
  output logic [XLEN-1:0]       o_write_data,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_mem_to_reg,
  output logic                  o_branch_taken,
  output logic [XLEN-1:0]       o_branch_target,
  output logic                  o_stall
);

  logic [2:0]      funct3;
  logic            op5;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result, ex_result;
  alu_fn_e         alu_fn;
  logic            cond_met, mul_active, stall;
  logic            unused_instr;

  assign funct3       = i_instruction[14:12];
  assign op5          = i_instruction[5];
  assign unused_instr = ^{i_instruction[24:15], i_instruction[11:6], i_instruction[4:0]};

  // Operand A forwarding: MEM beats WB, x0 never forwarded.
  always_comb begin
    fwd_a = i_read_data1;
    if (o_reg_write && o_rd != '0 && o_rd == i_rs1)
      fwd_a = o_alu_result;
    else if (i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == i_rs1)
      fwd_a = i_wb_data;
  end

  // Operand B forwarding, same priority as A.
  always_comb begin
    fwd_b = i_read_data2;
    if (o_reg_write && o_rd != '0 && o_rd == i_rs2)
      fwd_b = o_alu_result;
    else if (i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == i_rs2)
      fwd_b = i_wb_data;
  end

  assign op_b   = i_alu_src ? i_imm : fwd_b;
  assign alu_fn = alu_decode(i_alu_op, funct3, i_instruction[30], op5);

  ex_alu #(.XLEN(XLEN)) u_alu (
    .fn     (alu_fn),
    .a      (fwd_a),
    .b      (op_b),
    .result (alu_result)
  );

  // Branch condition on the forwarded register operands.
  always_comb begin
    cond_met = 1'b0;
    case (funct3)
      F3_BEQ:  cond_met = (fwd_a == fwd_b);
      F3_BNE:  cond_met = (fwd_a != fwd_b);
      F3_BLT:  cond_met = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  cond_met = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: cond_met = (fwd_a < fwd_b);
      F3_BGEU: cond_met = (fwd_a >= fwd_b);
      default: cond_met = 1'b0;
    endcase
  end

  assign o_branch_taken  = i_branch && cond_met && !mul_active;
  assign o_branch_target = i_pc + i_imm;
  assign o_stall         = stall;

`ifdef RV32M_MUL_EN
  localparam int CNT_W = $clog2(XLEN);

  mul_state_e        state_q, state_d;
  logic              is_mul, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mcand_q, hi_q, lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, high_q;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] raw, product;

  // Qualified by the R-type op class so stores/branches whose immediate
  // bits alias funct7=0000001 are not mistaken for multiplies.
  assign is_mul   = (i_alu_op == ALU_OP_FUNCT) && op5 &&
                    (i_instruction[31:25] == F7_MULDIV) && !funct3[2];
  assign a_signed = (funct3 != F3_MULHU);
  assign b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH);
  assign a_neg    = a_signed && fwd_a[XLEN-1];
  assign b_neg    = b_signed && fwd_b[XLEN-1];

  assign psum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign raw     = {hi_q, lo_q};
  assign product = neg_q ? -raw : raw;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= MUL_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state, stall and branch suppression.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    mul_active = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (is_mul) begin
          stall      = 1'b1;
          mul_active = 1'b1;
          state_d    = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        stall      = 1'b1;
        mul_active = 1'b1;
        if (cnt_q == '0) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        mul_active = 1'b1;
        state_d    = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Shift-add datapath: lo_q starts as the multiplier magnitude and is
  // shifted out as product bits shift in from the accumulator.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      high_q  <= 1'b0;
    end else if (state_q == MUL_IDLE && is_mul) begin
      mcand_q <= a_neg ? -fwd_a : fwd_a;
      lo_q    <= b_neg ? -fwd_b : fwd_b;
      hi_q    <= '0;
      cnt_q   <= CNT_W'(XLEN - 1);
      neg_q   <= a_neg ^ b_neg;
      high_q  <= (funct3 != F3_MUL);
    end else if (state_q == MUL_BUSY) begin
      hi_q  <= psum[XLEN:1];
      lo_q  <= {psum[0], lo_q[XLEN-1:1]};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign ex_result = (state_q == MUL_DONE) ?
                     (high_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0]) :
                     alu_result;
`else
  logic unused_funct7;

  assign unused_funct7 = ^{i_instruction[31], i_instruction[29:25]};
  assign stall         = 1'b0;
  assign mul_active    = 1'b0;
  assign ex_result     = alu_result;
`endif

  // EX/MEM pipeline register; a stalled cycle inserts an all-zero bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset || stall) begin
      o_alu_result <= '0;
      o_write_data <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
    end else begin
      o_alu_result <= ex_result;
      o_write_data <= fwd_b;
      o_rd         <= i_rd;
      o_reg_write  <= i_reg_write;
      o_mem_read   <= i_mem_read;
      o_mem_write  <= i_mem_write;
      o_mem_to_reg <= i_mem_to_reg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage. Multiply checks compile only when
// RV32M_MUL_EN is defined.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_pc = '0, i_instruction = '0, i_read_data1 = '0, i_read_data2 = '0, i_imm = '0;
  logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0, i_wb_rd = '0;
  logic        i_reg_write = 0, i_alu_src = 0, i_mem_read = 0, i_mem_write = 0;
  logic        i_mem_to_reg = 0, i_branch = 0, i_wb_reg_write = 0;
  logic [1:0]  i_alu_op = '0;
  logic [31:0] i_wb_data = '0;
  logic [31:0] o_alu_result, o_write_data, o_branch_target;
  logic [4:0]  o_rd;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch_taken, o_stall;

  always #5 clk = ~clk;

  ex_stage dut (
    .i_clk(clk), .i_reset(i_reset), .i_pc(i_pc), .i_instruction(i_instruction),
    .i_read_data1(i_read_data1), .i_read_data2(i_read_data2), .i_imm(i_imm),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_reg_write(i_reg_write),
    .i_alu_src(i_alu_src), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_to_reg(i_mem_to_reg), .i_branch(i_branch), .i_alu_op(i_alu_op),
    .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write), .i_wb_data(i_wb_data),
    .o_alu_result(o_alu_result), .o_write_data(o_write_data), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_branch_taken(o_branch_taken),
    .o_branch_target(o_branch_target), .o_stall(o_stall)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Reference EX/MEM contents
  logic [31:0] m_res, m_wdata;
  logic [4:0]  m_rd;
  logic        m_rw, m_mr, m_mw, m_m2r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] ins,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f3;
    int sh;
    f3 = ins[14:12];
    sh = int'(b[4:0]);
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b11) return b;
    case (f3)
      3'd0: return (ins[5] && ins[30]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_br(input logic br, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
    if (!br) return 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] idv);
    if (m_rw && m_rd != 0 && m_rd == rs) return m_res;
    if (i_wb_reg_write && i_wb_rd != 0 && i_wb_rd == rs) return i_wb_data;
    return idv;
  endfunction

  // Reference register update
  always @(posedge clk) begin : model_upd
    logic [31:0] fa, fb;
    fa = fwd(i_rs1, i_read_data1);
    fb = fwd(i_rs2, i_read_data2);
    if (i_reset) begin
      m_res <= '0; m_wdata <= '0; m_rd <= '0;
      m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0;
    end else begin
      m_res   <= ref_alu(i_alu_op, i_instruction, fa, i_alu_src ? i_imm : fb);
      m_wdata <= fb;
      m_rd    <= i_rd;
      m_rw    <= i_reg_write;
      m_mr    <= i_mem_read;
      m_mw    <= i_mem_write;
      m_m2r   <= i_mem_to_reg;
    end
  end

  // Per-cycle compare against the reference
  always @(negedge clk) begin : cmp
    logic [31:0] fa, fb;
    if (chk_en) begin
      fa = fwd(i_rs1, i_read_data1);
      fb = fwd(i_rs2, i_read_data2);
      check("alu_result",    o_alu_result, m_res);
      check("write_data",    o_write_data, m_wdata);
      check("rd",            32'(o_rd), 32'(m_rd));
      check("ctrl",          {28'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg},
                             {28'd0, m_rw, m_mr, m_mw, m_m2r});
      check("branch_taken",  32'(o_branch_taken), 32'(ref_br(i_branch, i_instruction[14:12], fa, fb)));
      check("branch_target", o_branch_target, i_pc + i_imm);
      check("stall",         32'(o_stall), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    i_instruction = '0; i_reg_write = 0; i_alu_src = 0; i_mem_read = 0; i_mem_write = 0;
    i_mem_to_reg = 0; i_branch = 0; i_alu_op = 2'b00; i_wb_reg_write = 0;
    i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_read_data1 = 0; i_read_data2 = 0; i_imm = 0; i_pc = 0;
  endtask

  task automatic rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    nop();
    i_instruction = mk(f7, f3, 7'b0110011);
    i_alu_op = 2'b10; i_rs1 = 5'd1; i_rs2 = 5'd2; i_rd = 5'd9; i_reg_write = 1;
    i_read_data1 = a; i_read_data2 = b;
  endtask

`ifdef RV32M_MUL_EN
  task automatic run_mul(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    bit bub_ok, br_ok;
    nop(); step(); step();
    rtype(7'b0000001, f3, a, b);
    i_rd = 5'd7; i_branch = 1;
    n = 0; bub_ok = 1; br_ok = 1;
    @(negedge clk);
    while (o_stall && n < 100) begin
      n++;
      if (o_branch_taken) br_ok = 0;
      @(negedge clk);
      if (o_reg_write | o_mem_read | o_mem_write | o_mem_to_reg) bub_ok = 0;
    end
    check({name, "_stall_cycles"}, n, 33);
    check({name, "_bubbles"}, 32'(bub_ok), 32'd1);
    check({name, "_branch_forced"}, 32'(br_ok && !o_branch_taken), 32'd1);
    step();
    nop();
    @(negedge clk);
    check({name, "_result"}, o_alu_result, exp);
    check({name, "_reg_write"}, 32'(o_reg_write), 32'd1);
    check({name, "_rd"}, 32'(o_rd), 32'd7);
  endtask
`endif

  initial begin
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;

    nop();
    i_reset = 1;
    step(); step();
    @(negedge clk);
    check("reset_alu_result", o_alu_result, 32'h0);
    check("reset_reg_write",  32'(o_reg_write), 32'h0);
    check("reset_rd",         32'(o_rd), 32'h0);
    check("reset_stall",      32'(o_stall), 32'h0);
    chk_en = 1;

    // ADD 5 + 7
    step();
    i_reset = 0;
    rtype(7'd0, 3'b000, 32'd5, 32'd7);
    i_rd = 5'd4;
    step();
    @(negedge clk);
    check("add_result", o_alu_result, 32'd12);
    check("add_reg_write", 32'(o_reg_write), 32'd1);
    check("add_rd", 32'(o_rd), 32'd4);

    // MEM beats WB on x3
    nop(); i_alu_op = 2'b00; i_alu_src = 1; i_imm = 32'h10; i_rd = 5'd3; i_reg_write = 1;
    step();
    nop(); i_alu_op = 2'b00; i_alu_src = 1; i_imm = 0; i_rs1 = 5'd3; i_rs2 = 5'd3;
    i_read_data1 = 32'h99; i_read_data2 = 32'h77; i_rd = 5'd5;
    i_wb_rd = 5'd3; i_wb_reg_write = 1; i_wb_data = 32'h20;
    step();
    @(negedge clk);
    check("fwd_mem_prio_a", o_alu_result, 32'h10);
    check("fwd_mem_prio_b", o_write_data, 32'h10);

    // x0 never forwarded
    nop(); i_alu_op = 2'b00; i_alu_src = 1; i_imm = 32'h10; i_rd = 5'd0; i_reg_write = 1;
    step();
    nop(); i_read_data2 = 32'd5; i_rd = 5'd6;
    i_wb_rd = 5'd0; i_wb_reg_write = 1; i_wb_data = 32'h20;
    step();
    @(negedge clk);
    check("x0_no_fwd_result", o_alu_result, 32'd5);
    check("x0_no_fwd_wdata", o_write_data, 32'd5);

    // BEQ taken, BLTU not taken
    nop(); i_instruction = mk(7'd0, 3'b000, 7'b1100011); i_alu_op = 2'b01; i_branch = 1;
    i_pc = 32'h100; i_imm = 32'h20; i_rs1 = 5'd1; i_rs2 = 5'd2;
    i_read_data1 = 32'h55; i_read_data2 = 32'h55;
    @(negedge clk);
    check("beq_taken", 32'(o_branch_taken), 32'd1);
    check("beq_target", o_branch_target, 32'h120);
    step();
    i_instruction = mk(7'd0, 3'b110, 7'b1100011);
    i_read_data1 = 32'hFFFF_FFFF; i_read_data2 = 32'd1;
    @(negedge clk);
    check("bltu_not_taken", 32'(o_branch_taken), 32'd0);

    // SRA / SLT / SLTU
    step();
    rtype(7'b0100000, 3'b101, 32'h8000_0000, 32'd4);
    step();
    rtype(7'd0, 3'b010, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check("sra", o_alu_result, 32'hF800_0000);
    step();
    rtype(7'd0, 3'b011, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check("slt", o_alu_result, 32'd1);
    step();
    nop();
    @(negedge clk);
    check("sltu", o_alu_result, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [6:0] f7;
      step();
      f7 = 7'($urandom);
      if ($urandom_range(0, 1) == 0) f7 = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'b0000000;
`ifdef RV32M_MUL_EN
      if (f7 == 7'b0000001) f7 = 7'b0000000;
`endif
      i_instruction = {f7, 10'($urandom), 3'($urandom), 5'($urandom), 7'($urandom)};
      i_alu_op       = 2'($urandom);
      i_rs1          = 5'($urandom_range(0, 3));
      i_rs2          = 5'($urandom_range(0, 3));
      i_rd           = 5'($urandom_range(0, 3));
      i_wb_rd        = 5'($urandom_range(0, 3));
      i_read_data1   = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      i_read_data2   = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      i_imm          = $urandom;
      i_pc           = $urandom;
      i_wb_data      = $urandom;
      i_reg_write    = 1'($urandom);
      i_alu_src      = 1'($urandom);
      i_mem_read     = 1'($urandom);
      i_mem_write    = 1'($urandom);
      i_mem_to_reg   = 1'($urandom);
      i_branch       = 1'($urandom);
      i_wb_reg_write = 1'($urandom);
    end
    step();
    nop();
    step();

`ifdef RV32M_MUL_EN
    chk_en = 0;
    run_mul("mulh", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
    run_mul("mul",  3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    run_mul("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Reset in the middle of BUSY
    nop(); step(); step();
    rtype(7'b0000001, 3'b000, 32'd3, 32'd5);
    for (int k = 0; k < 10; k++) step();
    i_reset = 1;
    nop();
    step();
    @(negedge clk);
    check("rst_busy_stall", 32'(o_stall), 32'd0);
    check("rst_busy_result", o_alu_result, 32'd0);
    check("rst_busy_ctrl", {28'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg}, 32'd0);
    check("rst_busy_rd", 32'(o_rd), 32'd0);
    step();
    i_reset = 0;
    step();
    @(negedge clk);
    check("post_rst_reg_write", 32'(o_reg_write), 32'd0);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
